// File: rtl/drp_seq_pkg.sv
// Shared definitions for the DRP read-modify-write sequencer.
//   - drp_state_e : FSM state encodings (also exported on state_out)
//   - STATE_W     : state encoding width
//   - IDX_W       : table index width (up to 16 entries)
//   - is_wait_state() : true for states that wait on drdy under a timeout
package drp_seq_pkg;

    localparam int STATE_W = 5;
    localparam int IDX_W   = 4;

    // Bit 3 marks per-entry wait states, bit 4 marks the final settle read.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 5'd0,
        ST_RD       = 5'd1,
        ST_WR       = 5'd2,
        ST_VRF_RD   = 5'd3,
        ST_WAIT_RD  = 5'd9,
        ST_WAIT_WR  = 5'd10,
        ST_WAIT_VRF = 5'd11,
        ST_FIN_RD   = 5'd16,
        ST_WAIT_FIN = 5'd17
    } drp_state_e;

    function automatic logic is_wait_state(input drp_state_e s);
        return (s == ST_WAIT_RD) || (s == ST_WAIT_WR) ||
               (s == ST_WAIT_VRF) || (s == ST_WAIT_FIN);
    endfunction

endpackage

// File: rtl/drp_timeout_counter.sv
// drdy wait counter for the DRP sequencer.
// Ports:
//   i_clk     : clock
//   i_rst_n   : synchronous active-low reset
//   i_clear   : zero the count (asserted whenever not waiting)
//   i_enable  : count one waiting cycle
//   o_expired : high during the TIMEOUT-th waiting cycle
module drp_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Count holds at TIMEOUT-1: the waiting cycle with that count is the
    // last one, so drdy seen there still counts as success upstream.
    assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/drp_rmw_sequencer.sv
// DRP read-modify-write sequencer for clock-manager reconfiguration.
// For each table entry with a nonzero mask: read the register, merge the
// masked data bits, write back, wait for drdy. Ends with a settle read of
// FINAL_ADDR. A drdy timeout aborts the run with a sticky error.
//
// Optional build macro: DRP_VERIFY_EN adds a readback-verify read after
// every write; a masked mismatch aborts the run with an error.
//
// Ports:
//   clock, reset         : clock, synchronous active-low reset
//   start, enable_change : run request (accepted in IDLE when both high)
//   cfg_addr/mask/data   : entry table, entry i at slice i; hold while busy
//   drp_do, drdy         : DRP read data and ready
//   den, dwe, drst       : DRP strobe, write enable, reset-hold during writes
//   di, daddr            : DRP write data and address
//   busy, done           : run in progress, one-cycle success pulse
//   error, err_index     : sticky failure flag and failing entry index
//   last_rd              : per-entry value read before modification
//   state_out            : current FSM state encoding
module drp_rmw_sequencer
    import drp_seq_pkg::*;
#(
    parameter int                N_ENTRIES  = 3,
    parameter int                ADDR_W     = 7,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] FINAL_ADDR = 7'h00,
    parameter int                TIMEOUT    = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          enable_change,
    input  logic [N_ENTRIES*ADDR_W-1:0]   cfg_addr,
    input  logic [N_ENTRIES*DATA_W-1:0]   cfg_mask,
    input  logic [N_ENTRIES*DATA_W-1:0]   cfg_data,
    input  logic [DATA_W-1:0]             drp_do,
    input  logic                          drdy,
    output logic                          den,
    output logic                          dwe,
    output logic                          drst,
    output logic [DATA_W-1:0]             di,
    output logic [ADDR_W-1:0]             daddr,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [3:0]                    err_index,
    output logic [N_ENTRIES*DATA_W-1:0]   last_rd,
    output logic [4:0]                    state_out
);

    drp_state_e                  r_state;
    drp_state_e                  w_next;
    logic [IDX_W-1:0]            r_idx;
    logic [DATA_W-1:0]           r_rd;
    logic [N_ENTRIES*DATA_W-1:0] r_last_rd;
    logic                        r_error;
    logic                        r_done;
    logic [3:0]                  r_err_idx;

    logic [IDX_W-1:0]  w_first_idx;
    logic [IDX_W-1:0]  w_nxt_idx;
    logic              w_first_ok;
    logic              w_nxt_ok;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [ADDR_W-1:0] w_after_addr;
    logic [DATA_W-1:0] w_cur_mask;
    logic [DATA_W-1:0] w_cur_data;
    logic [DATA_W-1:0] w_merge;
    logic              w_in_wait;
    logic              w_tmo_clr;
    logic              w_expired;
    logic              w_accept;
    logic              w_adv;
    logic              w_timeout;
    logic              w_finish;
    logic              w_vrf_fail;

    // ------------------------------------------------------------------
    // Entry scan: first active entry overall, and first active entry
    // after the current one. Descending loop so the lowest index wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_first_idx = '0;
        w_first_ok  = 1'b0;
        w_nxt_idx   = '0;
        w_nxt_ok    = 1'b0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (cfg_mask[i*DATA_W +: DATA_W] != '0) begin
                w_first_idx = IDX_W'(i);
                w_first_ok  = 1'b1;
                if (i > int'(r_idx)) begin
                    w_nxt_idx = IDX_W'(i);
                    w_nxt_ok  = 1'b1;
                end
            end
        end
    end

    assign w_cur_addr   = cfg_addr[int'(r_idx)*ADDR_W +: ADDR_W];
    assign w_cur_mask   = cfg_mask[int'(r_idx)*DATA_W +: DATA_W];
    assign w_cur_data   = cfg_data[int'(r_idx)*DATA_W +: DATA_W];
    // Address of whatever follows the current entry: next active entry
    // or, once the table is exhausted, the settle read.
    assign w_after_addr = w_nxt_ok ? cfg_addr[int'(w_nxt_idx)*ADDR_W +: ADDR_W]
                                   : FINAL_ADDR;
    assign w_merge      = (r_rd & ~w_cur_mask) | (w_cur_data & w_cur_mask);

`ifdef DRP_VERIFY_EN
    logic w_vrf_bad;
    assign w_vrf_bad = |((drp_do ^ w_cur_data) & w_cur_mask);
`endif

    // ------------------------------------------------------------------
    // drdy timeout: cleared outside wait states, so every wait starts at 0
    // ------------------------------------------------------------------
    assign w_in_wait = is_wait_state(r_state);
    assign w_tmo_clr = ~w_in_wait;

    drp_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_clear   (w_tmo_clr),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_adv      = 1'b0;
        w_timeout  = 1'b0;
        w_finish   = 1'b0;
        w_vrf_fail = 1'b0;
        den        = 1'b0;
        dwe        = 1'b0;
        drst       = 1'b0;
        di         = r_rd;
        daddr      = w_cur_addr;
        busy       = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (start && enable_change) begin
                    w_accept = 1'b1;
                    w_next   = w_first_ok ? ST_RD : ST_FIN_RD;
                end
            end
            ST_RD: begin
                den    = 1'b1;
                w_next = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (drdy) begin
                    w_next = ST_WR;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_WR: begin
                den    = 1'b1;
                dwe    = 1'b1;
                drst   = 1'b1;
                di     = w_merge;
                w_next = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                drst = 1'b1;
`ifdef DRP_VERIFY_EN
                // Verify read still targets this entry.
                daddr = w_cur_addr;
                if (drdy) begin
                    w_next = ST_VRF_RD;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
`else
                daddr = w_after_addr;
                if (drdy) begin
                    w_adv  = 1'b1;
                    w_next = w_nxt_ok ? ST_RD : ST_FIN_RD;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
`endif
            end
`ifdef DRP_VERIFY_EN
            ST_VRF_RD: begin
                den    = 1'b1;
                w_next = ST_WAIT_VRF;
            end
            ST_WAIT_VRF: begin
                daddr = w_after_addr;
                if (drdy) begin
                    if (w_vrf_bad) begin
                        w_vrf_fail = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = w_nxt_ok ? ST_RD : ST_FIN_RD;
                    end
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
`endif
            ST_FIN_RD: begin
                den    = 1'b1;
                daddr  = FINAL_ADDR;
                w_next = ST_WAIT_FIN;
            end
            ST_WAIT_FIN: begin
                daddr = FINAL_ADDR;
                if (drdy) begin
                    w_finish = 1'b1;
                    w_next   = ST_IDLE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: index, read capture, status
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idx     <= '0;
            r_rd      <= '0;
            r_last_rd <= '0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;

            if (w_accept) begin
                r_error   <= 1'b0;
                r_err_idx <= '0;
                r_idx     <= w_first_idx;
            end

            if (w_adv && w_nxt_ok) begin
                r_idx <= w_nxt_idx;
            end

            if (r_state == ST_WAIT_RD && drdy) begin
                r_rd                                    <= drp_do;
                r_last_rd[int'(r_idx)*DATA_W +: DATA_W] <= drp_do;
            end

            // The settle read reports N_ENTRIES as its index.
            if (w_timeout || w_vrf_fail) begin
                r_error   <= 1'b1;
                r_err_idx <= (r_state == ST_WAIT_FIN) ? 4'(N_ENTRIES) : r_idx;
            end
        end
    end

    assign done      = r_done;
    assign error     = r_error;
    assign err_index = r_err_idx;
    assign last_rd   = r_last_rd;
    assign state_out = r_state;

endmodule

// File: tb/tb_drp_rmw_sequencer.sv
module tb_drp_rmw_sequencer;

  localparam int N   = 3;
  localparam int AW  = 7;
  localparam int DW  = 16;
  localparam int TMO = 8;
  localparam logic [AW-1:0] FIN_A = 7'h00;

  localparam int EV_RD   = 0;
  localparam int EV_WR   = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          enable_change = 1'b0;
  logic [N*AW-1:0] cfg_addr = '0;
  logic [N*DW-1:0] cfg_mask = '0;
  logic [N*DW-1:0] cfg_data = '0;
  logic [DW-1:0] drp_do = '0;
  logic          drdy = 1'b0;
  logic          den, dwe, drst, busy, done, error;
  logic [DW-1:0] di;
  logic [AW-1:0] daddr;
  logic [3:0]    err_index;
  logic [N*DW-1:0] last_rd;
  logic [4:0]    state_out;

  drp_rmw_sequencer #(
    .N_ENTRIES(N), .ADDR_W(AW), .DATA_W(DW), .FINAL_ADDR(FIN_A), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .enable_change(enable_change),
    .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data),
    .drp_do(drp_do), .drdy(drdy), .den(den), .dwe(dwe), .drst(drst),
    .di(di), .daddr(daddr), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .last_rd(last_rd), .state_out(state_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    idx;
  } ev_t;

  int n_checks = 0;
  int n_errors = 0;
  int den_count = 0;
  ev_t sb[$];

  // DRP slave model state and knobs
  logic [DW-1:0] mem [128];
  int            dly = 3;
  bit            stall_en = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  bit            stall_we = 1'b0;
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] exp_last [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input int i);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.idx = 4'(i);
    sb.push_back(e);
  endtask

  task automatic set_entry(input int i, input logic [AW-1:0] a, input logic [DW-1:0] m,
                           input logic [DW-1:0] d);
    cfg_addr[i*AW +: AW] = a;
    cfg_mask[i*DW +: DW] = m;
    cfg_data[i*DW +: DW] = d;
  endtask

  task automatic set_basic();
    set_entry(0, 7'h50, 16'hFFFF, 16'h1234);
    set_entry(1, 7'h41, 16'h0004, 16'h0004);
    set_entry(2, 7'h51, 16'h000C, 16'h000C);
  endtask

  task automatic init_mem();
    for (int i = 0; i < 128; i++) mem[i] = 16'h00A0;
  endtask

  // Reference model: each active entry is read, merged under mask and
  // written back; then the settle read. Stalls and corruptions end the run.
  task automatic predict();
    logic [DW-1:0] m [128];
    logic [AW-1:0] a;
    logic [DW-1:0] mk, dt, v, w;
    m = mem;
    for (int i = 0; i < N; i++) begin
      a  = cfg_addr[i*AW +: AW];
      mk = cfg_mask[i*DW +: DW];
      dt = cfg_data[i*DW +: DW];
      if (mk != '0) begin
        push(EV_RD, a, '0, 0);
        if (stall_en && !stall_we && stall_addr == a) begin push(EV_ERR, '0, '0, i); return; end
        v = m[a];
        exp_last[i] = v;
        w = (v & ~mk) | (dt & mk);
        push(EV_WR, a, w, 0);
        m[a] = w;
        if (stall_en && stall_we && stall_addr == a) begin push(EV_ERR, '0, '0, i); return; end
`ifdef DRP_VERIFY_EN
        push(EV_RD, a, '0, 0);
        v = m[a];
        if (corrupt_en && a == corrupt_addr) v = v ^ 16'h0004;
        if (((v ^ dt) & mk) != '0) begin push(EV_ERR, '0, '0, i); return; end
`endif
      end
    end
    push(EV_RD, FIN_A, '0, 0);
    if (stall_en && !stall_we && stall_addr == FIN_A) begin push(EV_ERR, '0, '0, N); return; end
    push(EV_DONE, '0, '0, 0);
  endtask

  // DRP slave: drdy dly cycles after den, optionally withheld or corrupted.
  initial begin : drp_slave
    logic [AW-1:0] a, pa;
    logic          w, pw;
    logic [DW-1:0] v;
    bit            hold, abort;
    pa = '1; pw = 1'b0;
    forever begin
      @(negedge clock);
      while (reset && den) begin
        a = daddr; w = dwe;
        if (w) mem[a] = di;
        v = mem[a];
        if (corrupt_en && !w && pw && pa == a && a == corrupt_addr) v = v ^ 16'h0004;
        pa = a; pw = w;
        hold = stall_en && stall_addr == a && stall_we == w;
        if (hold) begin
          @(negedge clock);
        end else begin
          abort = 1'b0;
          for (int k = 0; k < dly && !abort; k++) begin
            @(negedge clock);
            if (!reset) abort = 1'b1;
          end
          if (!abort) begin
            drdy = 1'b1; drp_do = v;
            @(negedge clock);
            drdy = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every DRP strobe, done pulse and error rise.
  initial begin : monitor
    ev_t  e;
    logic pe;
    pe = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (den) begin
          den_count++;
          if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_den: got addr %0h we %0b, required no strobe", daddr, dwe);
          end else begin
            e = sb.pop_front();
            chk("den_kind", {63'd0, dwe}, (e.kind == EV_WR) ? 64'd1 : 64'd0);
            chk("den_addr", 64'(daddr), 64'(e.addr));
            if (e.kind == EV_WR) chk("wr_data", 64'(di), 64'(e.data));
          end
        end
        if (done || (error && !pe)) begin
          if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_end: got done %0b error %0b, required none", done, error);
          end else begin
            e = sb.pop_front();
            chk("end_kind", 64'(e.kind), done ? 64'(EV_DONE) : 64'(EV_ERR));
            if (!done) chk("err_index", 64'(err_index), 64'(e.idx));
          end
        end
      end
      pe = error;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input bit en);
    @(posedge clock); #1 start = 1'b1; enable_change = en;
    @(posedge clock); #1 start = 1'b0; enable_change = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 2000) begin @(negedge clock); c++; end
    chk(name, 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_end(input string name);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    for (int i = 0; i < N; i++) chk({name, "_last_rd"}, 64'(last_rd[i*DW +: DW]), 64'(exp_last[i]));
  endtask

  task automatic run(input string name);
    predict();
    pulse_start(1'b1);
    wait_idle({name, "_idle"});
    check_end(name);
  endtask

  initial begin : main
    int c, n, dc;
    init_mem();
    for (int i = 0; i < N; i++) exp_last[i] = '0;
    set_basic();

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_den", 64'(den), 0);   chk("rst_dwe", 64'(dwe), 0);
    chk("rst_drst", 64'(drst), 0); chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0); chk("rst_error", 64'(error), 0);
    chk("rst_err_index", 64'(err_index), 0); chk("rst_di", 64'(di), 0);
    chk("rst_last_rd", 64'(last_rd), 0);    chk("rst_state", 64'(state_out), 0);
    chk("rst_daddr", 64'(daddr), 64'h50);
    @(posedge clock); #1 reset = 1'b1;

    // Basic sequence
    run("basic");

    // Skipped entry
    init_mem();
    set_entry(1, 7'h41, 16'h0000, 16'h0004);
    run("skip");

    // drdy exactly at the last allowed wait cycle
    init_mem(); set_basic(); dly = TMO;
    run("edge_dly");
    dly = 3;

    // All masks zero: only the settle read
    for (int i = 0; i < N; i++) set_entry(i, 7'(i + 5), 16'h0000, 16'hFFFF);
    run("all_zero");

    // Timeout in WAIT_WR of entry 2
    init_mem(); set_basic();
    stall_en = 1'b1; stall_addr = 7'h51; stall_we = 1'b1;
    predict();
    pulse_start(1'b1);
    c = 0;
    while (!(den && dwe && daddr == 7'h51) && c < 500) begin @(negedge clock); c++; end
    chk("tmo_wr_seen", 64'(den && dwe && daddr == 7'h51), 64'd1);
    n = 0;
    do begin @(negedge clock); n++; end while (busy && n < 100);
    chk("tmo_cycles", 64'(n), 64'(TMO + 1));
    repeat (3) @(negedge clock);
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_err_index", 64'(err_index), 64'd2);
    check_end("tmo");
    stall_en = 1'b0;
    predict();
    pulse_start(1'b1);
    chk("tmo_clr_error", 64'(error), 64'd0);
    chk("tmo_clr_err_index", 64'(err_index), 64'd0);
    wait_idle("tmo_rerun_idle");
    check_end("tmo_rerun");

    // Reset mid-write
    init_mem(); set_basic();
    predict();
    pulse_start(1'b1);
    c = 0;
    while (state_out != 5'd10 && c < 500) begin @(negedge clock); c++; end
    chk("rstw_in_wait_wr", 64'(state_out), 64'd10);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    sb.delete();
    for (int i = 0; i < N; i++) exp_last[i] = '0;
    chk("rstw_den", 64'(den), 0);   chk("rstw_dwe", 64'(dwe), 0);
    chk("rstw_drst", 64'(drst), 0); chk("rstw_busy", 64'(busy), 0);
    chk("rstw_state", 64'(state_out), 0);
    init_mem();
    run("rstw_rerun");

    // Start gating: enable_change low
    dc = den_count;
    pulse_start(1'b0);
    repeat (10) @(negedge clock);
    chk("gate_busy", 64'(busy), 0);
    chk("gate_den_count", 64'(den_count), 64'(dc));

    // Start while busy
    init_mem();
    predict();
    pulse_start(1'b1);
    repeat (4) @(negedge clock);
    start = 1'b1; enable_change = 1'b1;
    @(negedge clock);
    start = 1'b0; enable_change = 1'b0;
    wait_idle("busy_start_idle");
    check_end("busy_start");

`ifdef DRP_VERIFY_EN
    // Readback corruption on entry 1
    init_mem(); set_basic();
    corrupt_en = 1'b1; corrupt_addr = 7'h41;
    run("verify");
    chk("vrf_error", 64'(error), 64'd1);
    chk("vrf_err_index", 64'(err_index), 64'd1);
    corrupt_en = 1'b0;
`endif

    // Randomized tables, contents and latencies
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++) begin
        logic [AW-1:0] ra;
        ra = 7'($urandom_range(0, 127));
        set_entry(i, ra, ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                  16'($urandom));
        mem[ra] = 16'($urandom);
      end
      dly = $urandom_range(1, TMO);
      run("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
